// File: rtl/debouncer_multi.sv
// debouncer_multi: N independent input debouncers with synchronisers,
// registered debounced levels, rise/fall event pulses, busy flags and a
// global enable.
module debouncer_multi #(
  parameter int unsigned      N_CH        = 4,
  parameter int unsigned      CNT_MAX     = 300000,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [N_CH-1:0]  DEFAULT_D   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] i_d,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy
);

  localparam int unsigned     CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  s;

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];

  logic [N_CH-1:0] q_q, q_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] busy_q, busy_d;

  // Synchroniser shift chain; only the last stage feeds the filters.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel stability filter: counts consecutive mismatches of s vs q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!en) begin
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_STABLE: begin
            if (s[i] != q_q[i]) begin
              if (CNT_MAX == 1) begin
                // No filtering: the first mismatching sample is accepted.
                q_d[i]    = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
              end else begin
                state_d[i] = ST_COUNT;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          ST_COUNT: begin
            if (s[i] == q_q[i]) begin
              // Input went back before the window closed: glitch rejected.
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              q_d[i]     = s[i];
              rise_d[i]  = s[i];
              fall_d[i]  = ~s[i];
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      busy_d[i] = (state_d[i] == ST_COUNT);
    end
  end

  // State, counters, synchronisers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{DEFAULT_D}};
      q_q    <= DEFAULT_D;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync_q  <= sync_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised N-channel successor to the single-bit button debouncer.
- Each channel: own synchroniser, stability counter and debounced output. Adds one-cycle rise/fall event pulses, a per-channel busy flag and a global enable.
- Sits between raw board inputs (buttons, switches) and the core/control logic.
- All channels share one clock and reset.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- CNT_MAX, 300000, consecutive stable sampled cycles required before q changes (>=1). 10 ms at 30 MHz.
- CNT_W, $clog2(CNT_MAX+1), counter width (derived, not overridden).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEFAULT_D, {N_CH{1'b0}}, per-channel reset/idle level of q and of the synchroniser flops.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, global enable; 0 freezes q and clears all counters.
- i_d, input, N_CH, raw asynchronous inputs.
- q, output, N_CH, debounced levels (registered).
- rise, output, N_CH, one-cycle pulse when q[i] goes 0->1.
- fall, output, N_CH, one-cycle pulse when q[i] goes 1->0.
- busy, output, N_CH, 1 while channel i is counting a candidate change.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchroniser flops[i] = DEFAULT_D[i]; q = DEFAULT_D.
  - Counters 0; rise = fall = busy = 0.
  - Release is synchronous to clk. The first sample is taken on the first rising edge with rst=1.
- Synchroniser: i_d[i] passes through SYNC_STAGES flops. s[i] is the last stage. Only s[i] is used downstream.
- Per-channel FSM, 2 states:
  - STABLE: counter = 0, busy = 0. If en=1 and s != q, go to COUNT with counter = 1.
  - COUNT: busy = 1.
    - If s == q: return to STABLE, counter = 0, no output change (glitch rejected).
    - Else if counter == CNT_MAX-1: q <= s, rise/fall pulse, go to STABLE, counter = 0.
    - Else: counter + 1.
- Net rule: q[i] takes the value of s[i] on the edge that ends the CNT_MAX-th consecutive cycle in which s[i] != q[i].
- Latency from a clean i_d step to q change: SYNC_STAGES + CNT_MAX clk edges.
- CNT_MAX = 1: q follows s one cycle later with no filtering. busy is never seen high.
- rise[i] = 1 and fall[i] = 0 exactly in the cycle where q[i] first reads 1 after being 0; fall is the mirror case. Pulses are registered alongside q, last exactly 1 cycle, and are never both high.
- Counter never exceeds CNT_MAX-1, so it cannot wrap.
- en = 0:
  - All channels are forced to STABLE with counter 0.
  - q holds its value; rise, fall and busy are 0.
  - Synchronisers keep sampling.
  - When en returns to 1, a mismatch present then starts a fresh count from 1.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Reset mid-count: count is discarded; q returns to DEFAULT_D with no rise/fall pulse.
- No combinational path from i_d or en to any output.

Test Plan:
- N_CH=4, CNT_MAX=4, DEFAULT_D=0. After reset, hold i_d=4'b0001 stable -> q[0] rises exactly 6 edges after the i_d change. rise=4'b0001 for one cycle, busy[0] high for 3 cycles before it, fall=0.
- Bounce on ch1: i_d[1] toggles 1,0,1,0 each cycle, then holds 1 -> no q/rise activity during the bounce. q[1]=1 is reached 6 edges after the final hold begins.
- Release: after q[2]=1, drive i_d[2]=0 stable -> fall[2] pulses once, q[2]=0. A 3-cycle low glitch instead -> q[2] stays 1, busy drops, no fall.
- Parallel: i_d 0000->1111 in one cycle -> all q bits change in the same cycle, rise=4'b1111 for 1 cycle.
- en: drop en mid-count on ch3 (counter=2) for 5 cycles with i_d[3]=1 held -> q[3] unchanged, busy=0. After en=1, q[3] rises 4 edges later.
- Async reset: assert rst=0 mid-count and between clock edges -> q=DEFAULT_D and busy=0 immediately. No pulses after release, and a normal debounce works afterwards. Repeat with DEFAULT_D=4'b1010.
